// File: rtl/seven_seg_mode_controller_pkg.sv
// Shared definitions for the seven-segment mode controller: mode codes,
// switch role indices, segment bit map and the hex-to-segment decode table.
package seven_seg_mode_controller_pkg;

  typedef enum logic [1:0] {
    STATE_INIT   = 2'd0,
    STATE_AUTO   = 2'd1,
    STATE_SWITCH = 2'd2,
    STATE_BIT    = 2'd3
  } state_e;

  localparam int unsigned SW_SEL_AUTO   = 0;
  localparam int unsigned SW_SEL_SWITCH = 1;
  localparam int unsigned SW_SEL_BIT    = 2;
  localparam int unsigned SW_HOME       = 3;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Active-high pattern, bit0 = A .. bit6 = G.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_mode_controller_hex_to_segments.sv
// Segment driver: hex decode or raw pattern override, then pin polarity.
module hex_to_segments
  import seven_seg_mode_controller_pkg::*;
#(
  parameter int g_SEG_ACTIVE_LOW = 0
) (
  input  logic [3:0] i_Value,
  input  logic       i_Raw_En,
  input  logic [6:0] i_Raw,
  output logic [6:0] o_Segments
);

  logic [6:0] seg_high;

  always_comb begin
    seg_high   = i_Raw_En ? i_Raw : hex_to_seg(i_Value);
    o_Segments = (g_SEG_ACTIVE_LOW != 0) ? ~seg_high : seg_high;
  end

endmodule

// File: rtl/seven_seg_mode_controller.sv
// Mode-selecting controller for one 7-segment digit: spinner idle, timed hex
// count, manual inc/dec and live switch display, selected by switch releases.
module seven_seg_mode_controller
  import seven_seg_mode_controller_pkg::*;
#(
  parameter int g_CLKS_PER_STEP  = 25000000 / 6,
  parameter int g_SPIN_LEN       = 6,
  parameter int g_AUTO_MAX       = 15,
  parameter int g_SEG_ACTIVE_LOW = 0
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [3:0] i_Switches,
  output logic [1:0] o_State,
  output logic [3:0] o_Value,
  output logic       o_Paused,
  output logic [6:0] o_Segments
);

  localparam int CNT_W = (g_CLKS_PER_STEP > 0) ? $clog2(g_CLKS_PER_STEP + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(g_CLKS_PER_STEP);
  localparam logic [2:0]       SPIN_LAST = 3'(g_SPIN_LEN - 1);
  localparam logic [3:0]       AUTO_MAX  = 4'(g_AUTO_MAX);

  if (g_SPIN_LEN < 2 || g_SPIN_LEN > 7) begin : g_bad_spin_len
    $error("g_SPIN_LEN must be in 2..7");
  end
  if (g_AUTO_MAX < 1 || g_AUTO_MAX > 15) begin : g_bad_auto_max
    $error("g_AUTO_MAX must be in 1..15");
  end

  state_e           state_q, state_d;
  logic [2:0]       spin_q, spin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       value_q, value_d;
  logic             paused_q, paused_d;
  logic [3:0]       hist_q, hist_d;

  logic [3:0] rel;
  logic       counting;
  logic       tick;
  logic [6:0] spin_raw;

  always_comb begin
    rel      = hist_q & ~i_Switches;
    counting = (state_q == STATE_INIT) || ((state_q == STATE_AUTO) && !paused_q);
    tick     = counting && (cnt_q == CNT_MAX);

    state_d  = state_q;
    spin_d   = spin_q;
    value_d  = value_q;
    paused_d = paused_q;
    hist_d   = i_Switches;
    cnt_d    = counting ? (tick ? '0 : cnt_q + CNT_W'(1)) : cnt_q;

    case (state_q)
      STATE_INIT: begin
        if (tick) spin_d = (spin_q == SPIN_LAST) ? '0 : spin_q + 3'd1;
        if (rel[SW_SEL_AUTO])        state_d = STATE_AUTO;
        else if (rel[SW_SEL_SWITCH]) state_d = STATE_SWITCH;
        else if (rel[SW_SEL_BIT])    state_d = STATE_BIT;
      end
      STATE_AUTO: begin
        if (tick) value_d = (value_q == AUTO_MAX) ? '0 : value_q + 4'd1;
        if (rel[SW_SEL_AUTO]) paused_d = !paused_q;
      end
      STATE_SWITCH: begin
        if (rel[0] && !rel[1])      value_d = value_q + 4'd1;
        else if (rel[1] && !rel[0]) value_d = value_q - 4'd1;
      end
      STATE_BIT:  value_d = i_Switches;
      default:    state_d = STATE_INIT;
    endcase

    if ((state_q != STATE_INIT) && rel[SW_HOME]) state_d = STATE_INIT;

    // Any mode change overrides the per-mode updates above.
    if (state_d != state_q) begin
      cnt_d    = '0;
      value_d  = '0;
      paused_d = 1'b0;
      if (state_d == STATE_INIT) spin_d = '0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q  <= STATE_INIT;
      spin_q   <= '0;
      cnt_q    <= '0;
      value_q  <= '0;
      paused_q <= 1'b0;
      hist_q   <= '0;
    end else begin
      state_q  <= state_d;
      spin_q   <= spin_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      paused_q <= paused_d;
      hist_q   <= hist_d;
    end
  end

  assign o_State  = state_q;
  assign o_Value  = value_q;
  assign o_Paused = paused_q;
  assign spin_raw = 7'd1 << spin_q;

  hex_to_segments #(
    .g_SEG_ACTIVE_LOW(g_SEG_ACTIVE_LOW)
  ) u_hex_to_segments (
    .i_Value    (value_q),
    .i_Raw_En   (state_q == STATE_INIT),
    .i_Raw      (spin_raw),
    .o_Segments (o_Segments)
  );

endmodule

// File: tb/tb_seven_seg_mode_controller.sv
// Directed bench for seven_seg_mode_controller; an active-high and an
// active-low instance share the same stimulus.
module tb_seven_seg_mode_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'd0;

  logic [1:0] state_hi, state_lo;
  logic [3:0] value_hi, value_lo;
  logic       paused_hi, paused_lo;
  logic [6:0] seg_hi, seg_lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  seven_seg_mode_controller #(
    .g_CLKS_PER_STEP(3), .g_SPIN_LEN(6), .g_AUTO_MAX(9), .g_SEG_ACTIVE_LOW(0)
  ) dut_hi (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switches(sw),
    .o_State(state_hi), .o_Value(value_hi), .o_Paused(paused_hi), .o_Segments(seg_hi)
  );

  seven_seg_mode_controller #(
    .g_CLKS_PER_STEP(3), .g_SPIN_LEN(6), .g_AUTO_MAX(9), .g_SEG_ACTIVE_LOW(1)
  ) dut_lo (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switches(sw),
    .o_State(state_lo), .o_Value(value_lo), .o_Paused(paused_lo), .o_Segments(seg_lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sw    = 4'd0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Press then release the given switches; outputs reflect the release afterwards.
  task automatic release_sw(input logic [3:0] mask);
    sw = mask;
    tick();
    sw = 4'd0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (state_hi !== 2'd0 || value_hi !== 4'd0 || paused_hi !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: state=%0d value=%0h paused=%0b expected 0 0 0",
               state_hi, value_hi, paused_hi);
    end
    n_checks++;
    if (seg_hi !== 7'h01 || seg_lo !== 7'h7E) begin
      n_fail++;
      $display("FAIL reset_segs: hi=%h lo=%h expected 01 7e", seg_hi, seg_lo);
    end
  endtask

  task automatic test_spin();
    logic [6:0] exp;
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      tick();
      exp = 7'd1 << ((k / 4) % 6);
      n_checks++;
      if (seg_hi !== exp || seg_lo !== ~exp) begin
        n_fail++;
        $display("FAIL spin_k%0d: hi=%h lo=%h expected %h %h", k, seg_hi, seg_lo, exp, ~exp);
      end
    end
    n_checks++;
    if (state_hi !== 2'd0) begin
      n_fail++;
      $display("FAIL spin_state: state=%0d expected 0", state_hi);
    end
  endtask

  task automatic test_switch_mode();
    do_reset();
    release_sw(4'b0010);
    n_checks++;
    if (state_hi !== 2'd2 || value_hi !== 4'd0) begin
      n_fail++;
      $display("FAIL switch_enter: state=%0d value=%0h expected 2 0", state_hi, value_hi);
    end
    for (int i = 0; i < 3; i++) release_sw(4'b0001);
    release_sw(4'b0010);
    n_checks++;
    if (value_hi !== 4'd2) begin
      n_fail++;
      $display("FAIL switch_inc_dec: value=%0h expected 2", value_hi);
    end
    release_sw(4'b0010);
    release_sw(4'b0010);
    release_sw(4'b0010);
    n_checks++;
    if (value_hi !== 4'hF || seg_hi !== 7'h71 || seg_lo !== 7'h0E) begin
      n_fail++;
      $display("FAIL switch_underflow: value=%0h hi=%h lo=%h expected f 71 0e",
               value_hi, seg_hi, seg_lo);
    end
    release_sw(4'b0011);
    n_checks++;
    if (value_hi !== 4'hF || state_hi !== 2'd2) begin
      n_fail++;
      $display("FAIL switch_both: value=%0h state=%0d expected f 2", value_hi, state_hi);
    end
    release_sw(4'b1000);
    n_checks++;
    if (state_hi !== 2'd0 || value_hi !== 4'd0 || seg_hi !== 7'h01) begin
      n_fail++;
      $display("FAIL switch_home: state=%0d value=%0h segs=%h expected 0 0 01",
               state_hi, value_hi, seg_hi);
    end
  endtask

  task automatic test_auto();
    logic [3:0] exp;
    do_reset();
    release_sw(4'b0001);
    n_checks++;
    if (state_hi !== 2'd1 || value_hi !== 4'd0 || paused_hi !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_enter: state=%0d value=%0h paused=%0b expected 1 0 0",
               state_hi, value_hi, paused_hi);
    end
    for (int k = 1; k <= 44; k++) begin
      tick();
      exp = 4'((k / 4) % 10);
      n_checks++;
      if (value_hi !== exp || seg_hi !== hex_tbl[exp]) begin
        n_fail++;
        $display("FAIL auto_count_k%0d: value=%0h segs=%h expected %0h %h",
                 k, value_hi, seg_hi, exp, hex_tbl[exp]);
      end
    end
    release_sw(4'b0001);
    n_checks++;
    if (paused_hi !== 1'b1 || value_hi !== 4'd1) begin
      n_fail++;
      $display("FAIL auto_pause: paused=%0b value=%0h expected 1 1", paused_hi, value_hi);
    end
    for (int k = 0; k < 20; k++) tick();
    n_checks++;
    if (value_hi !== 4'd1 || paused_hi !== 1'b1) begin
      n_fail++;
      $display("FAIL auto_frozen: value=%0h paused=%0b expected 1 1", value_hi, paused_hi);
    end
    release_sw(4'b0001);
    n_checks++;
    if (paused_hi !== 1'b0 || value_hi !== 4'd1) begin
      n_fail++;
      $display("FAIL auto_unpause: paused=%0b value=%0h expected 0 1", paused_hi, value_hi);
    end
    for (int k = 0; k < 8; k++) tick();
    n_checks++;
    if (value_hi !== 4'd3) begin
      n_fail++;
      $display("FAIL auto_resume: value=%0h expected 3", value_hi);
    end
    release_sw(4'b1001);
    n_checks++;
    if (state_hi !== 2'd0 || value_hi !== 4'd0 || paused_hi !== 1'b0 || seg_hi !== 7'h01) begin
      n_fail++;
      $display("FAIL auto_home_wins: state=%0d value=%0h paused=%0b segs=%h expected 0 0 0 01",
               state_hi, value_hi, paused_hi, seg_hi);
    end
  endtask

  task automatic test_bit();
    do_reset();
    release_sw(4'b0100);
    n_checks++;
    if (state_hi !== 2'd3) begin
      n_fail++;
      $display("FAIL bit_enter: state=%0d expected 3", state_hi);
    end
    sw = 4'b0101;
    tick();
    n_checks++;
    if (value_hi !== 4'd5 || seg_hi !== 7'h6D || seg_lo !== 7'h12) begin
      n_fail++;
      $display("FAIL bit_load5: value=%0h hi=%h lo=%h expected 5 6d 12", value_hi, seg_hi, seg_lo);
    end
    sw = 4'b1010;
    tick();
    n_checks++;
    if (value_hi !== 4'hA || seg_hi !== 7'h77) begin
      n_fail++;
      $display("FAIL bit_loadA: value=%0h segs=%h expected a 77", value_hi, seg_hi);
    end
    sw = 4'b0000;
    tick();
    n_checks++;
    if (state_hi !== 2'd0 || value_hi !== 4'd0) begin
      n_fail++;
      $display("FAIL bit_home: state=%0d value=%0h expected 0 0", state_hi, value_hi);
    end
  endtask

  task automatic test_decode_polarity();
    do_reset();
    release_sw(4'b0100);
    for (int v = 0; v < 8; v++) begin
      sw = 4'(v);
      tick();
      n_checks++;
      if (value_hi !== 4'(v) || seg_hi !== hex_tbl[v] || seg_lo !== ~hex_tbl[v]) begin
        n_fail++;
        $display("FAIL decode_v%0d: value=%0h hi=%h lo=%h expected %0h %h %h",
                 v, value_hi, seg_hi, seg_lo, v, hex_tbl[v], ~hex_tbl[v]);
      end
    end
  endtask

  task automatic test_reset_mid_auto();
    do_reset();
    release_sw(4'b0001);
    for (int k = 0; k < 28; k++) tick();
    n_checks++;
    if (value_hi !== 4'd7) begin
      n_fail++;
      $display("FAIL midreset_pre: value=%0h expected 7", value_hi);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (state_hi !== 2'd0 || value_hi !== 4'd0 || paused_hi !== 1'b0 ||
        seg_hi !== 7'h01 || seg_lo !== 7'h7E || state_lo !== 2'd0) begin
      n_fail++;
      $display("FAIL midreset_post: state=%0d value=%0h paused=%0b hi=%h lo=%h expected 0 0 0 01 7e",
               state_hi, value_hi, paused_hi, seg_hi, seg_lo);
    end
  endtask

  initial begin
    test_reset();
    test_spin();
    test_switch_mode();
    test_auto();
    test_bit();
    test_decode_polarity();
    test_reset_mid_auto();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
